// File: rtl/axi_tdd_ng_pkg.sv
// Shared types for the TDD frame counter and its sync scheduler.
package axi_tdd_ng_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    WAITING = 2'd2,
    RUNNING = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    S_DISABLED = 2'd0,
    S_READY    = 2'd1,
    S_HOLDOFF  = 2'd2
  } sync_state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    SOFT = 2'd1,
    EXT  = 2'd2,
    INT  = 2'd3
  } sync_src_t;

endpackage

// File: rtl/axi_tdd_ng_sync_ctrl_if.sv
// Control/status bundle between the TDD register map, the frame
// counter and the sync scheduler.
interface axi_tdd_ng_sync_ctrl_if #(
  parameter int unsigned REGISTER_WIDTH = 32,
  parameter int unsigned HOLDOFF_WIDTH  = 16,
  parameter int unsigned MISSED_WIDTH   = 16
) ();
  import axi_tdd_ng_pkg::*;

  logic                      tdd_enable;
  state_t                    tdd_cstate;
  logic                      asy_tdd_sync_int_en;
  logic                      asy_tdd_sync_ext_en;
  logic [REGISTER_WIDTH-1:0] asy_tdd_sync_period;
  logic [HOLDOFF_WIDTH-1:0]  asy_tdd_sync_holdoff;
  logic                      tdd_sync_soft;
  logic                      tdd_sync_missed_clr;
  logic                      tdd_sync;
  sync_src_t                 tdd_sync_src;
  logic [MISSED_WIDTH-1:0]   tdd_sync_missed;

  modport master (
    output tdd_enable, tdd_cstate,
    output asy_tdd_sync_int_en, asy_tdd_sync_ext_en,
    output asy_tdd_sync_period, asy_tdd_sync_holdoff,
    output tdd_sync_soft, tdd_sync_missed_clr,
    input  tdd_sync, tdd_sync_src, tdd_sync_missed
  );

  modport slave (
    input  tdd_enable, tdd_cstate,
    input  asy_tdd_sync_int_en, asy_tdd_sync_ext_en,
    input  asy_tdd_sync_period, asy_tdd_sync_holdoff,
    input  tdd_sync_soft, tdd_sync_missed_clr,
    output tdd_sync, tdd_sync_src, tdd_sync_missed
  );

endinterface

// File: rtl/axi_tdd_ng_sync_filter.sv
// sync_in synchronizer and rising-edge detector; TDD_SYNC_DEGLITCH_EN
// requires DEGLITCH_CYCLES stable-high cycles before an edge counts.
module axi_tdd_ng_sync_filter #(
  parameter int unsigned DEGLITCH_CYCLES = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic sync_in,
  output logic sync_edge
);

  localparam int unsigned CW = $clog2(DEGLITCH_CYCLES + 1);
`ifdef TDD_SYNC_DEGLITCH_EN
  localparam int unsigned NCYC = DEGLITCH_CYCLES;
`else
  localparam int unsigned NCYC = 1;
`endif
  localparam logic [CW-1:0] FULL = CW'(NCYC);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] hi_cnt_q, hi_cnt_d;
  logic          lvl_q, lvl_d;

  always_comb begin
    sync_d   = {sync_q[0], sync_in};
    hi_cnt_d = '0;
    if (sync_q[1]) begin
      hi_cnt_d = (hi_cnt_q == FULL) ? hi_cnt_q
                                    : hi_cnt_q + CW'(1);
    end
    lvl_d = (hi_cnt_q == FULL);
  end

  assign sync_edge = lvl_d & ~lvl_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q   <= '0;
      hi_cnt_q <= '0;
      lvl_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      hi_cnt_q <= hi_cnt_d;
      lvl_q    <= lvl_d;
    end
  end

endmodule

// File: rtl/axi_tdd_ng_sync_ctrl.sv
// TDD sync scheduler: merges soft/ext/int requests into one gated pulse.
// Optional deglitch on sync_in via TDD_SYNC_DEGLITCH_EN.
module axi_tdd_ng_sync_ctrl
  import axi_tdd_ng_pkg::*;
#(
  parameter int unsigned REGISTER_WIDTH  = 32,
  parameter int unsigned HOLDOFF_WIDTH   = 16,
  parameter int unsigned MISSED_WIDTH    = 16,
  parameter int unsigned DEGLITCH_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    sync_in,
  axi_tdd_ng_sync_ctrl_if.slave   bus
);

  sync_state_t               state_q, state_d;
  logic                      tdd_sync_q, tdd_sync_d;
  sync_src_t                 src_q, src_d;
  logic [MISSED_WIDTH-1:0]   missed_q, missed_d;
  logic [HOLDOFF_WIDTH-1:0]  hold_q, hold_d;
  logic [REGISTER_WIDTH-1:0] int_cnt_q, int_cnt_d;
  logic                      int_en_q;

  logic ext_edge, ext_req, int_req, soft_req;
  logic req, fire, miss, load, en;

  axi_tdd_ng_sync_filter #(
    .DEGLITCH_CYCLES (DEGLITCH_CYCLES)
  ) u_filter (
    .clk       (clk),
    .resetn    (resetn),
    .sync_in   (sync_in),
    .sync_edge (ext_edge)
  );

  assign en       = bus.tdd_enable;
  assign soft_req = bus.tdd_sync_soft;
  assign ext_req  = ext_edge & bus.asy_tdd_sync_ext_en;
  assign load     = (state_q == S_DISABLED) |
                    (bus.asy_tdd_sync_int_en & ~int_en_q);
  assign int_req  = bus.asy_tdd_sync_int_en &
                    (|bus.asy_tdd_sync_period) &
                    (int_cnt_q == '0) & ~load;
  assign req      = soft_req | ext_req | int_req;

  // The cycle right after a pulse never fires, even with zero holdoff.
  assign fire = en & (state_q == S_READY) & req &
                (bus.tdd_cstate == ARMED) & ~tdd_sync_q;
  assign miss = en & (state_q != S_DISABLED) & req & ~fire;

  always_comb begin
    int_cnt_d = int_cnt_q - REGISTER_WIDTH'(1);
    if (!en) begin
      int_cnt_d = '0;
    end else if (load || int_cnt_q == '0) begin
      int_cnt_d = bus.asy_tdd_sync_period - REGISTER_WIDTH'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    tdd_sync_d = 1'b0;
    src_d      = src_q;
    hold_d     = hold_q;
    unique case (state_q)
      S_DISABLED: begin
        if (en) state_d = S_READY;
      end
      S_READY: begin
        if (fire) begin
          tdd_sync_d = 1'b1;
          hold_d     = bus.asy_tdd_sync_holdoff;
          if (soft_req)     src_d = SOFT;
          else if (ext_req) src_d = EXT;
          else              src_d = INT;
          if (|bus.asy_tdd_sync_holdoff) state_d = S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        if (!tdd_sync_q) begin
          if (hold_q <= HOLDOFF_WIDTH'(1)) state_d = S_READY;
          else hold_d = hold_q - HOLDOFF_WIDTH'(1);
        end
      end
      default: state_d = S_DISABLED;
    endcase
    if (!en) begin
      state_d    = S_DISABLED;
      tdd_sync_d = 1'b0;
      hold_d     = '0;
    end
  end

  always_comb begin
    missed_d = missed_q;
    if (bus.tdd_sync_missed_clr) begin
      missed_d = '0;
    end else if (miss && !(&missed_q)) begin
      missed_d = missed_q + MISSED_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_DISABLED;
      tdd_sync_q <= 1'b0;
      src_q      <= NONE;
      missed_q   <= '0;
      hold_q     <= '0;
      int_cnt_q  <= '0;
      int_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tdd_sync_q <= tdd_sync_d;
      src_q      <= src_d;
      missed_q   <= missed_d;
      hold_q     <= hold_d;
      int_cnt_q  <= int_cnt_d;
      int_en_q   <= bus.asy_tdd_sync_int_en;
    end
  end

  assign bus.tdd_sync        = tdd_sync_q;
  assign bus.tdd_sync_src    = src_q;
  assign bus.tdd_sync_missed = missed_q;

endmodule
